// File: rtl/mcu_pkg.sv
// mcu_pkg: opcodes, instruction field positions and FSM states shared by the sequencer and its decoder.
package mcu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam logic [1:0] OP_J = 2'b11;
  localparam logic [7:0] HALT_WORD = 8'hC3;
  localparam int OP_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 2;
  localparam int RD_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;
endpackage

// File: rtl/mcu_decode.sv
// mcu_decode: splits an instruction word into opcode, register selects, sign-extended offset and halt flag.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic [1:0] o_op,
  output logic [1:0] o_rs,
  output logic [1:0] o_rt,
  output logic [1:0] o_rd,
  output logic [7:0] o_imm,
  output logic       o_is_halt
);
  assign o_op = i_ir[OP_LSB+:2];
  assign o_rs = i_ir[RS_LSB+:2];
  assign o_rt = i_ir[RT_LSB+:2];
  // LW writes its loaded value back into rt, so the write select follows rt there
  assign o_rd = (o_op == OP_LW) ? o_rt : i_ir[RD_LSB+:2];
  assign o_imm = {{6{i_ir[1]}}, i_ir[1:0]};
  assign o_is_halt = (i_ir == HALT_WORD);
endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multi-cycle fetch/decode/execute control unit for the 8-bit 4-register CPU.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int ROM_DEPTH = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] address,
  input  logic [7:0]      instruction,
  output logic [1:0]      rs_sel,
  output logic [1:0]      rt_sel,
  output logic [1:0]      rd_sel,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [7:0]      imm,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            instr_done,
  output logic            halted,
  output logic            fault
);
  state_t r_state, w_state;
  logic [PC_W-1:0] r_pc, w_pc;
  logic [7:0] r_ir, w_ir;
  logic r_fault, w_fault;
  logic w_done;
  logic [1:0] w_op;
  logic w_is_halt;
  logic [PC_W-1:0] w_pc_inc, w_jofs;
  state_t w_after;
  mcu_decode u_decode (
    .i_ir     (r_ir),
    .o_op     (w_op),
    .o_rs     (rs_sel),
    .o_rt     (rt_sel),
    .o_rd     (rd_sel),
    .o_imm    (imm),
    .o_is_halt(w_is_halt)
  );
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_jofs = {{(PC_W - 6){r_ir[5]}}, r_ir[5:0]};
  assign w_after = run ? S_FETCH : S_IDLE;
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_ir <= w_ir;
      r_fault <= w_fault;
    end
  end
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_ir = r_ir;
    w_fault = r_fault;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: w_state = (run || step) ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (32'(r_pc) >= ROM_DEPTH) begin
          w_fault = 1'b1;
          w_state = S_HALT;
        end else begin
          w_ir = instruction;
          w_state = S_DECODE;
        end
      end
      S_DECODE: w_state = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_op == OP_J) begin
          w_pc = w_pc_inc + w_jofs;
          w_done = 1'b1;
          w_state = w_after;
        end else begin
          w_state = (w_op == OP_ADD) ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_state = (w_op == OP_LW) ? S_WB : w_after;
          w_pc = (w_op == OP_LW) ? r_pc : w_pc_inc;
          w_done = (w_op != OP_LW);
        end
      end
      S_WB: begin
        w_pc = w_pc_inc;
        w_done = 1'b1;
        w_state = w_after;
      end
      S_HALT: w_state = S_HALT;
      default: w_state = S_IDLE;
    endcase
  end
  assign address = r_pc;
  assign rf_we = (r_state == S_WB);
  assign wb_sel = (r_state == S_WB) && (w_op == OP_LW);
  assign mem_req = (r_state == S_MEM);
  assign mem_we = (r_state == S_MEM) && (w_op == OP_SW);
  assign instr_done = w_done;
  assign halted = (r_state == S_HALT);
  assign fault = r_fault;
endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed bench with ROM, register-file and data-memory models around the sequencer.
module tb_mcu_sequencer;
  logic clk = 1'b0;
  logic clear, run, step, mem_ack;
  logic [7:0] address, instruction, imm;
  logic [1:0] rs_sel, rt_sel, rd_sel;
  logic rf_we, wb_sel, mem_req, mem_we, instr_done, halted, fault;
  logic [7:0] rom [32];
  logic [7:0] regs [4];
  logic [7:0] dmem [256];
  logic [7:0] wlog_v [16];
  logic [1:0] wlog_rd [16];
  int wn, done_cnt, req_cnt, ack_delay, checks, errors;
  logic ack_en;
  logic [7:0] maddr, wval;
  logic [7:0] exp_v [8] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
  logic [1:0] exp_rd [8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

  always #5 clk = ~clk;

  mcu_sequencer dut (
    .clk(clk), .clear(clear), .run(run), .step(step), .address(address),
    .instruction(instruction), .rs_sel(rs_sel), .rt_sel(rt_sel), .rd_sel(rd_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .imm(imm), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .instr_done(instr_done), .halted(halted), .fault(fault)
  );

  assign instruction = (address < 8'd32) ? rom[address[4:0]] : 8'h00;
  assign mem_ack = mem_req && ack_en && (req_cnt >= ack_delay);
  assign maddr = regs[rs_sel] + imm;
  assign wval = wb_sel ? dmem[maddr] : regs[rs_sel] + regs[rt_sel];

  always @(posedge clk) begin
    req_cnt <= mem_req ? req_cnt + 1 : 0;
    if (clear) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i);
      wn <= 0;
      done_cnt <= 0;
    end else begin
      if (rf_we) begin
        regs[rd_sel] <= wval;
        if (wn < 16) begin
          wlog_v[wn] <= wval;
          wlog_rd[wn] <= rd_sel;
        end
        wn <= wn + 1;
      end
      if (mem_req && mem_ack && mem_we) dmem[maddr] <= regs[rt_sel];
      if (instr_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    run = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    int n;
    logic bad;
    checks = 0;
    errors = 0;
    ack_en = 1'b1;
    ack_delay = 0;
    req_cnt = 0;
    do_clear();
    chk("reset_addr", address, 0);
    chk("reset_flags", {halted, fault, rf_we, mem_req, mem_we, instr_done, wb_sel}, 0);
    chk("reset_sel", {rs_sel, rt_sel, rd_sel, imm}, 0);

    // Fibonacci program under free run
    do_clear();
    rom[0] = 8'h49; rom[1] = 8'h27; rom[2] = 8'h39; rom[3] = 8'h18; rom[4] = 8'h07;
    rom[5] = 8'h32; rom[6] = 8'h2D; rom[7] = 8'h18; rom[8] = 8'hC3;
    run = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) tick();
    chk("fib_halted", halted, 1);
    chk("fib_done_cnt", done_cnt, 8);
    chk("fib_writes", wn, 8);
    chk("fib_halt_pc", address, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("fib_wr%0d", i), {wlog_rd[i], wlog_v[i]}, {exp_rd[i], exp_v[i]});
    run = 1'b0;
    pulse_step();
    run = 1'b1;
    tick();
    tick();
    chk("fib_halt_stays", {halted, address, 8'(done_cnt)}, {1'b1, 8'd8, 8'd8});

    // HALT word at PC=3 after three ADDs
    do_clear();
    rom[3] = 8'hC3;
    run = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("halt3_decode", {halted, 8'(done_cnt), address}, {1'b0, 8'd3, 8'd3});
    tick();
    chk("halt3_halted", halted, 1);
    run = 1'b0;
    pulse_step();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    chk("halt3_ignore", {halted, 8'(done_cnt), address, instr_done}, {1'b1, 8'd3, 8'd3, 1'b0});

    // single step of LW with a second step during MEM
    do_clear();
    rom[0] = 8'h49;
    rom[1] = 8'h8B;
    ack_delay = 3;
    pulse_step();
    for (int i = 0; i < 3; i++) tick();
    chk("step_in_mem", {mem_req, mem_we, address}, {1'b1, 1'b0, 8'd0});
    pulse_step();
    for (int i = 0; i < 8; i++) tick();
    chk("step_one_done", done_cnt, 1);
    chk("step_addr", address, 1);
    chk("step_write", {8'(wn), 6'd0, wlog_rd[0], wlog_v[0]}, {8'd1, 6'd0, 2'd2, 8'd1});
    chk("step_idle", {mem_req, rf_we, instr_done}, 0);

    // SW with ack delayed 5 cycles, negative offset to dmem[255]
    ack_delay = 5;
    pulse_step();
    for (int i = 0; i < 3; i++) tick();
    chk("sw_imm", imm, 8'hFF);
    n = 0;
    bad = 1'b0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      if (mem_we) n++;
      if (address !== 8'd1) bad = 1'b1;
      tick();
    end
    chk("sw_stall_len", n, 6);
    chk("sw_pc_held", bad, 0);
    chk("sw_after", {address, 8'(done_cnt)}, {8'd2, 8'd2});
    chk("sw_stored", dmem[255], 1);
    ack_delay = 0;

    // jump backwards from PC 0 wraps to FF, then fetch faults
    do_clear();
    rom[0] = 8'hFE;
    run = 1'b1;
    tick(); tick(); tick();
    chk("j_done", {instr_done, address}, {1'b1, 8'd0});
    tick();
    chk("j_target", {address, fault, halted}, {8'hFF, 1'b0, 1'b0});
    tick();
    chk("j_fault", {fault, halted, 8'(done_cnt)}, {1'b1, 1'b1, 8'd1});

    // clear in the middle of a stalled MEM
    rom[0] = 8'h49;
    run = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_fault", {fault, halted, address}, 0);
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("clr_in_mem", mem_req, 1);
    clear = 1'b1;
    run = 1'b0;
    tick();
    clear = 1'b0;
    chk("clr_drop", {mem_req, mem_we, rf_we, instr_done, halted, fault, address}, 0);
    tick(); tick();
    chk("clr_idle", {mem_req, address, 8'(done_cnt)}, 0);
    ack_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit, 4-register teaching CPU.
- Drives the instruction-ROM address and latches the returned instruction.
- Decodes the instruction and sequences the register file, adder and data-memory handshake, one instruction at a time.
- Sits between the instruction ROM and the datapath; supports free-run and single-step for board debug.

Parameters:
- PC_W, 8, width of the program counter and ROM address.
- ROM_DEPTH, 32, number of valid instruction words; fetching a PC at or above this value is a fault.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- clear  in  1  reset; synchronous, active-high.
- run  in  1  level; 1 = execute continuously.
- step  in  1  one-cycle pulse; executes exactly one instruction while run=0.
- address  out  PC_W  instruction-ROM address (= PC).
- instruction  in  8  combinational ROM data for address.
- rs_sel  out  2  register-file read port A select.
- rt_sel  out  2  register-file read port B select.
- rd_sel  out  2  register-file write select.
- rf_we  out  1  register-file write enable, one cycle.
- wb_sel  out  1  write-back source: 0 = adder, 1 = memory read data.
- imm  out  8  sign-extended instr[1:0] (LW/SW offset).
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store, valid while mem_req=1.
- mem_ack  in  1  data memory completes the request.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  1 in HALT state.
- fault  out  1  sticky; PC was at or above ROM_DEPTH at fetch.

Behaviour:
- Decode, op = instr[7:6]:
  - 00 ADD: rd[1:0] <= rs[5:4] + rt[3:2], mod 256.
  - 01 LW: rt[3:2] <= dmem[rs + sext(instr[1:0])].
  - 10 SW: dmem[rs + sext(instr[1:0])] <= rt.
  - 11 J: PC <= PC + 1 + sext(instr[5:0]), mod 2^PC_W.
  - Exception: exactly 8'hC3 is HALT, not a jump.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- clear (any state, any cycle, including mid-MEM):
  - Next cycle is IDLE, PC = RESET_PC, IR = 0, fault = 0.
  - All outputs 0 except address = RESET_PC.
  - An outstanding mem_req is dropped without waiting for mem_ack.
- IDLE -> FETCH when run=1 or step=1. A step received while run=1 is ignored.
- FETCH:
  - If PC >= ROM_DEPTH: fault <= 1, go to HALT.
  - Otherwise IR <= instruction, go to DECODE.
- DECODE: drive rs_sel/rt_sel/rd_sel/imm from IR; go to EXEC. IR = C3 goes to HALT instead.
- EXEC:
  - ADD -> WB.
  - LW/SW -> MEM.
  - J: load the jump target into PC, pulse instr_done, go to FETCH if run=1, else IDLE.
- MEM:
  - mem_req = 1; mem_we = 1 for SW. Hold both until mem_ack; no timeout.
  - An ack in the same cycle mem_req first rises is accepted.
  - On ack: LW -> WB; SW: PC+1, instr_done, then FETCH or IDLE per run.
- WB:
  - rf_we = 1 for one cycle; wb_sel = 1 for LW, 0 for ADD.
  - PC <= PC+1 (wraps at 2^PC_W), instr_done pulses, then FETCH or IDLE per run.
- Latency (mem_ack immediate): ADD 4 cycles, LW 5, SW 4, J 3, FETCH-to-FETCH.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE.
- HALT: halted = 1; exits only on clear. step and run are ignored.
- Selects and imm hold stable from DECODE until the instruction retires.

Decomposition:
- Shared package mcu_pkg:
  - opcode constants (OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11);
  - HALT_WORD = 8'hC3;
  - state enum;
  - field-position constants.
- One sub-module, mcu_decode: combinational IR -> op, rs, rt, rd, imm and is_halt. It is reused by the datapath checker.

Test Plan:
- Fibonacci program: 01001001, then ADD sequence 27,39,18,07,32,2D,18, then C3; with dmem[1]=1 and run=1.
  - Required: halted after the 9th instruction_fetch; 8 instr_done pulses; rf write sequence 1,1,2,3,5,8,13,21 to rd 2,3,1,0,3,2,1,0.
- Single step: run=0, step pulse with PC=0 (LW).
  - Required: exactly one instr_done, FSM in IDLE, address=1.
  - A second step pulse while in MEM is ignored.
- Memory stall: SW with mem_ack delayed 5 cycles.
  - Required: mem_req and mem_we held high for 6 cycles; PC unchanged until the ack cycle.
- Jump wrap: IR=8'b11111110 at PC=0.
  - Required: PC = 0 + 1 - 2 = 8'hFF; next FETCH sets fault=1 and halted=1.
- clear asserted during MEM with mem_ack=0.
  - Required: next cycle mem_req=0, address=0, IDLE; fault cleared.
- HALT word C3 at PC=3.
  - Required: halted=1 after DECODE; no instr_done for C3; run/step toggles cause no state change.
